// File: rtl/dmem_bridge.sv
// Memory-stage data-side adapter: captures one load/store, maps kseg0/kseg1 to
// physical, runs the req/addr_ok/data_ok handshake and stalls the pipeline meanwhile.
module dmem_bridge #(
    parameter int KSEG_MAP = 1,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_m,
    input  logic [3:0]        we_m,
    input  logic [1:0]        size_m,
    input  logic [31:0]       addr_m,
    input  logic [DATA_W-1:0] wdata_m,
    input  logic              cancel_m,
    output logic [DATA_W-1:0] rdata_m,
    output logic              stall_m,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              issue;
    logic [31:0]       mapped_addr;

    // Reset is folded in so the stall drops in the very cycle reset is asserted.
    assign issue = (state_q == IDLE) && en_m && !cancel_m && !reset;

    assign mapped_addr = ((KSEG_MAP != 0) && (addr_m[31:30] == 2'b10))
                         ? {3'b000, addr_m[28:0]} : addr_m;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    wr_d    = |we_m;
                    size_d  = size_m;
                    addr_d  = mapped_addr;
                    wdata_d = wdata_m;
                end
            end
            REQ: begin
                if (data_addr_ok) begin
                    req_d = 1'b0;
                    if (data_data_ok) begin
                        state_d = HOLD;
                        if (!wr_q) begin
                            rdata_d = data_rdata;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (data_data_ok) begin
                    state_d = HOLD;
                    if (!wr_q) begin
                        rdata_d = data_rdata;
                    end
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall_m    = issue || (state_q == REQ) || (state_q == WAIT);
    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign rdata_m    = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: a mapped and an unmapped instance share one
// stimulus stream; expected bus fields and load data are queued at issue.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_m;
    logic [3:0]  we_m;
    logic [1:0]  size_m;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic        cancel_m;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    logic [31:0] rdata_m, data_addr, data_wdata;
    logic        stall_m, data_req, data_wr;
    logic [1:0]  data_size;

    logic [31:0] n_rdata_m, n_data_addr, n_data_wdata;
    logic        n_stall_m, n_data_req, n_data_wr;
    logic [1:0]  n_data_size;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] addr_nm;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_bridge #(.KSEG_MAP(1), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .en_m(en_m), .we_m(we_m), .size_m(size_m),
        .addr_m(addr_m), .wdata_m(wdata_m), .cancel_m(cancel_m),
        .rdata_m(rdata_m), .stall_m(stall_m), .data_req(data_req),
        .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok)
    );

    dmem_bridge #(.KSEG_MAP(0), .DATA_W(32)) dut_nomap (
        .clk(clk), .reset(reset), .en_m(en_m), .we_m(we_m), .size_m(size_m),
        .addr_m(addr_m), .wdata_m(wdata_m), .cancel_m(cancel_m),
        .rdata_m(n_rdata_m), .stall_m(n_stall_m), .data_req(n_data_req),
        .data_wr(n_data_wr), .data_size(n_data_size), .data_addr(n_data_addr),
        .data_wdata(n_data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic checkReqPhase();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb[0];
        checkOutput("req_valid", {31'd0, data_req}, 32'd1);
        checkOutput("req_stall", {31'd0, stall_m}, 32'd1);
        checkOutput("req_addr", data_addr, e.addr);
        checkOutput("req_wr", {31'd0, data_wr}, {31'd0, e.wr});
        checkOutput("req_size", {30'd0, data_size}, {30'd0, e.size});
        checkOutput("req_wdata", data_wdata, e.wdata);
        checkOutput("nomap_addr", n_data_addr, e.addr_nm);
        checkOutput("nomap_ctl", {28'd0, n_data_req, n_data_wr, n_data_size},
                    {28'd0, 1'b1, e.wr, e.size});
        checkOutput("nomap_wdata", n_data_wdata, e.wdata);
    endtask

    task automatic applyStimulus(input logic [3:0] we, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_addr, input logic [31:0] exp_addr_nm,
                                 input int addr_wait, input bit same_cycle, input int data_wait,
                                 input logic [31:0] slave_rdata, input logic [31:0] exp_rdata,
                                 input int exp_stall, input bit keep_en);
        exp_t e;
        int   stall_seen;
        stall_seen = 0;
        @(negedge clk);
        en_m = 1'b1; cancel_m = 1'b0; we_m = we; size_m = sz;
        addr_m = addr; wdata_m = wdata;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        e.addr = exp_addr; e.addr_nm = exp_addr_nm; e.wr = (we != 4'd0);
        e.size = sz; e.wdata = wdata; e.rdata = exp_rdata;
        sb.push_back(e);
        #1;
        checkOutput("issue_req", {31'd0, data_req}, 32'd0);
        if (stall_m) stall_seen++;
        for (int i = 0; i <= addr_wait; i++) begin
            @(negedge clk);
            we_m = 4'hF; size_m = 2'd2; addr_m = 32'hFFFF_FFFC; wdata_m = 32'hFFFF_FFFF;
            data_addr_ok = (i == addr_wait);
            data_data_ok = same_cycle && (i == addr_wait);
            data_rdata   = data_data_ok ? slave_rdata : 32'h5A5A_5A5A;
            #1;
            checkReqPhase();
            if (stall_m) stall_seen++;
        end
        if (!same_cycle) begin
            for (int j = 0; j <= data_wait; j++) begin
                @(negedge clk);
                data_addr_ok = (j != data_wait);
                data_data_ok = (j == data_wait);
                data_rdata   = data_data_ok ? slave_rdata : 32'hA5A5_A5A5;
                #1;
                checkOutput("wait_req", {31'd0, data_req}, 32'd0);
                if (stall_m) stall_seen++;
            end
        end
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        en_m = keep_en;
        #1;
        checkOutput("hold_stall", {31'd0, stall_m}, 32'd0);
        checkOutput("hold_req", {31'd0, data_req}, 32'd0);
        e = sb.pop_front();
        checkOutput("hold_rdata", rdata_m, e.rdata);
        checkOutput("nomap_rdata", n_rdata_m, e.rdata);
        checkOutput("stall_cycles", stall_seen, exp_stall);
    endtask

    task automatic idleCycle(input string tag);
        @(negedge clk);
        en_m = 1'b0; cancel_m = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        checkOutput({tag, "_stall"}, {31'd0, stall_m}, 32'd0);
        checkOutput({tag, "_req"}, {31'd0, data_req}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; en_m = 1'b0; we_m = 4'd0; size_m = 2'd0; addr_m = 32'd0;
        wdata_m = 32'd0; cancel_m = 1'b0; data_addr_ok = 1'b0;
        data_rdata = 32'd0; data_data_ok = 1'b0;
        #2;
        checkOutput("rst_outs", {28'd0, stall_m, data_req, data_wr, |data_size}, 32'd0);
        checkOutput("rst_addr", data_addr, 32'd0);
        checkOutput("rst_wdata", data_wdata, 32'd0);
        checkOutput("rst_rdata", rdata_m, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Word load through kseg0, zero-wait slave.
        applyStimulus(4'b0000, 2'd2, 32'h8000_0010, 32'h0, 32'h0000_0010, 32'h8000_0010,
                      0, 1'b0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 1'b0);
        idleCycle("post_load");

        // Byte store through kseg1 with a slow addr_ok; load data must not move.
        applyStimulus(4'b0100, 2'd0, 32'hA000_0003, 32'h00AB_0000, 32'h0000_0003, 32'hA000_0003,
                      4, 1'b0, 0, 32'h5555_5555, 32'hDEAD_BEEF, 7, 1'b0);
        idleCycle("post_store");

        // Cancelled request never leaves IDLE.
        @(negedge clk);
        en_m = 1'b1; cancel_m = 1'b1; we_m = 4'd0; addr_m = 32'h8000_0000;
        #1;
        checkOutput("cancel_stall", {31'd0, stall_m}, 32'd0);
        checkOutput("cancel_req", {31'd0, data_req}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("cancel_req2", {31'd0, data_req}, 32'd0);
        idleCycle("post_cancel");

        // addr_ok and data_ok together in the first REQ cycle.
        applyStimulus(4'b0000, 2'd2, 32'h0000_0100, 32'h0, 32'h0000_0100, 32'h0000_0100,
                      0, 1'b1, 0, 32'h1234_5678, 32'h1234_5678, 2, 1'b0);
        idleCycle("post_same");

        // Back-to-back loads with en_m held through HOLD.
        applyStimulus(4'b0000, 2'd2, 32'hBFC0_0000, 32'h0, 32'h1FC0_0000, 32'hBFC0_0000,
                      0, 1'b0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, 1'b1);
        applyStimulus(4'b0000, 2'd1, 32'h8000_0022, 32'h0, 32'h0000_0022, 32'h8000_0022,
                      0, 1'b0, 2, 32'h0000_BEEF, 32'h0000_BEEF, 5, 1'b0);
        idleCycle("post_b2b");

        // Reset while waiting for data, then a late data_ok.
        @(negedge clk);
        en_m = 1'b1; we_m = 4'd0; size_m = 2'd2; addr_m = 32'h8000_0040;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        checkOutput("rstw_wait_stall", {31'd0, stall_m}, 32'd1);
        checkOutput("rstw_wait_rdata", rdata_m, 32'h0000_BEEF);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstw_stall", {31'd0, stall_m}, 32'd0);
        checkOutput("rstw_req", {31'd0, data_req}, 32'd0);
        checkOutput("rstw_rdata", rdata_m, 32'd0);
        checkOutput("rstw_addr", data_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0; en_m = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        #1;
        checkOutput("late_ok_stall", {31'd0, stall_m}, 32'd0);
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        checkOutput("late_ok_rdata", rdata_m, 32'd0);
        checkOutput("late_ok_req", {31'd0, data_req}, 32'd0);
        idleCycle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Memory-stage data-side bus adapter between the MIPS datapath and a handshaked, variable-latency SRAM-like data bus.
- Captures one load/store request from the memory stage and translates kseg0/kseg1 virtual addresses to physical.
- Drives the request/address/data handshake and returns read data to the datapath.
- Holds the pipeline with a stall until the transaction completes.

Parameters:
- KSEG_MAP, 1, when 1 map addresses 0x8000_0000–0xBFFF_FFFF to physical by clearing addr[31:29]; when 0 pass the address unchanged.
- DATA_W, 32, data bus width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en_m  in  1  memory-stage instruction is a load or store.
- we_m  in  4  byte write enables; 0 means read.
- size_m  in  2  access size: 0 byte, 1 half, 2 word.
- addr_m  in  32  virtual byte address.
- wdata_m  in  32  store data, already lane-aligned.
- cancel_m  in  1  exception or flush in the memory stage; suppresses issue.
- rdata_m  out  32  load data returned to the datapath.
- stall_m  out  1  freeze the pipeline while an access is outstanding.
- data_req  out  1  bus request valid.
- data_wr  out  1  1 = write, 0 = read.
- data_size  out  2  registered copy of size_m.
- data_addr  out  32  physical address.
- data_wdata  out  32  registered copy of wdata_m.
- data_addr_ok  in  1  slave accepted the request.
- data_rdata  in  32  slave read data.
- data_data_ok  in  1  slave completed the transfer; data_rdata is valid this cycle.

Behaviour:
- Reset: asynchronous, active-high, all state cleared.
  - State goes to IDLE.
  - data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, rdata_m=0.
  - stall_m=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - If en_m && !cancel_m, register data_wr=|we_m, data_size, mapped data_addr and data_wdata, then go to REQ.
  - stall_m=1 combinationally in that same cycle.
  - Otherwise stall_m=0.
- REQ:
  - data_req=1; all bus outputs are held stable until data_addr_ok.
  - data_addr_ok && data_data_ok in the same cycle: capture, then go to HOLD.
  - data_addr_ok alone: go to WAIT.
  - stall_m=1.
- WAIT:
  - data_req=0, stall_m=1.
  - On data_data_ok: go to HOLD. If the access is a read, rdata_m <= data_rdata.
- HOLD:
  - stall_m=0 for exactly one cycle; the pipeline advances at the end of this cycle.
  - en_m is ignored in this cycle, so the same instruction is never reissued.
  - Next state: IDLE.
- rdata_m:
  - Updates only on data_data_ok of a read.
  - Otherwise holds its value; writes never change it.
- Address mapping when KSEG_MAP=1:
  - addr_m[31:30]==2'b10 → data_addr = {3'b000, addr_m[28:0]}.
  - Else data_addr = addr_m.
- cancel_m is sampled only in IDLE.
  - Once in REQ or WAIT the transaction always completes; it is never withdrawn mid-handshake.
- Stray data_addr_ok in IDLE/WAIT/HOLD and stray data_data_ok in IDLE/REQ(without addr_ok)/HOLD are ignored.
- Minimum latency with zero-wait slave (addr_ok in REQ, data_ok the next cycle): stall_m high for 3 cycles (IDLE, REQ, WAIT), then low in HOLD.
- At most one transaction is outstanding; no pipelining of requests.
- Reset asserted mid-transaction: immediate return to IDLE with outputs cleared; the slave is reset by the same signal.

Test Plan:
- Word load at 0x8000_0010, slave addr_ok in 1st REQ cycle, data_ok next cycle with 0xDEADBEEF → data_addr=0x0000_0010, data_wr=0, stall_m high 3 cycles, rdata_m=0xDEADBEEF from HOLD onward.
- Byte store we_m=4'b0100 at 0xA000_0003, wdata_m=0x00AB0000, addr_ok delayed 4 cycles → data_req held 5 cycles with stable data_addr=0x0000_0003, data_wr=1, data_size=0; rdata_m unchanged.
- en_m=1 with cancel_m=1 in IDLE → no data_req, stall_m=0, state stays IDLE.
- addr_ok and data_ok in the same REQ cycle (data 0x12345678) → goes directly to HOLD, stall_m high 2 cycles, rdata_m=0x12345678.
- KSEG_MAP=0, load at 0xBFC0_0000 → data_addr=0xBFC0_0000; back-to-back en_m held through HOLD issues the second request only from IDLE, one cycle after HOLD.
- Reset pulse while in WAIT → same cycle state IDLE, stall_m=0, data_req=0, rdata_m=0; a late data_ok after reset is ignored.
